// File: rtl/adc_ctrl_regfile.sv
// AXI4-Lite register file for the ADC front end: config words, read-only
// status words, a command FIFO drained over AXI-Stream, and a control/status
// register for the FIFO.
module adc_ctrl_regfile #(
  parameter int NUM_CFG    = 2,
  parameter int NUM_STATUS = 2,
  parameter int CMD_DEPTH  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic [32*NUM_CFG-1:0]   cfg,
  input  logic [32*NUM_STATUS-1:0] status,
  output logic [31:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [31:0]             s_axi_lite_awaddr,
  input  logic [2:0]              s_axi_lite_awprot,
  input  logic                    s_axi_lite_awvalid,
  output logic                    s_axi_lite_awready,
  input  logic [31:0]             s_axi_lite_wdata,
  input  logic [3:0]              s_axi_lite_wstrb,
  input  logic                    s_axi_lite_wvalid,
  output logic                    s_axi_lite_wready,
  output logic [1:0]              s_axi_lite_bresp,
  output logic                    s_axi_lite_bvalid,
  input  logic                    s_axi_lite_bready,
  input  logic [31:0]             s_axi_lite_araddr,
  input  logic [2:0]              s_axi_lite_arprot,
  input  logic                    s_axi_lite_arvalid,
  output logic                    s_axi_lite_arready,
  output logic [31:0]             s_axi_lite_rdata,
  output logic [1:0]              s_axi_lite_rresp,
  output logic                    s_axi_lite_rvalid,
  input  logic                    s_axi_lite_rready
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int LW = PW + 1;
  localparam int WA = ADDR_WIDTH - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Word indices: config 0..15, status 16..31, CMD 32, CTRL 33
  localparam logic [31:0] IDX_STATUS = 32'd16;
  localparam logic [31:0] IDX_CMD    = 32'd32;
  localparam logic [31:0] IDX_CTRL   = 32'd33;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic          aw_done, w_done;
  logic [WA-1:0] aw_word_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;

  logic          aw_hs, w_hs, ar_hs, pop;
  logic          commit;
  logic [31:0]   c_idx, c_data;
  logic [3:0]    c_strb;
  logic          hit_cfg, hit_cmd, hit_ctrl, cmd_ok;
  logic          push, ovf_set, ovf_clr, flush, cfg_we;
  logic [1:0]    wr_resp;

  logic [31:0]   cfg_q [NUM_CFG];
  logic [31:0]   mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, empty, overflow;

  logic [31:0]   r_idx, rd_val;
  logic [1:0]    rd_resp;

  logic          unused_ok;
  assign unused_ok = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                       s_axi_lite_awaddr[31:ADDR_WIDTH], s_axi_lite_awaddr[1:0],
                       s_axi_lite_araddr[31:ADDR_WIDTH], s_axi_lite_araddr[1:0]};

  assign aw_hs = s_axi_lite_awvalid & s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid & s_axi_lite_wready;
  assign ar_hs = s_axi_lite_arvalid & s_axi_lite_arready;

  assign empty         = (count == '0);
  assign full          = (count == LW'(CMD_DEPTH));
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = mem[rd_ptr];
  assign pop           = m_axis_tvalid & m_axis_tready;

  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    assign cfg[32*gi +: 32] = cfg_q[gi];
  end

  // Commit-cycle decode: a channel handshaking this cycle bypasses its latch
  always_comb begin
    c_idx    = aw_hs ? 32'(s_axi_lite_awaddr[ADDR_WIDTH-1:2]) : 32'(aw_word_q);
    c_data   = w_hs ? s_axi_lite_wdata : wdata_q;
    c_strb   = w_hs ? s_axi_lite_wstrb : wstrb_q;
    commit   = (wstate == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    hit_cfg  = (c_idx < 32'(NUM_CFG));
    hit_cmd  = (c_idx == IDX_CMD);
    hit_ctrl = (c_idx == IDX_CTRL);
    cmd_ok   = hit_cmd && (c_strb == 4'hF);
    push     = commit && cmd_ok && !full;
    ovf_set  = commit && cmd_ok && full;
    flush    = commit && hit_ctrl && c_strb[0] && c_data[0];
    ovf_clr  = commit && hit_ctrl && c_strb[1] && c_data[8];
    cfg_we   = commit && hit_cfg;
    wr_resp  = (hit_cfg || hit_ctrl || (cmd_ok && !full)) ? OKAY : SLVERR;
  end

  // Write channel FSM: latch AW and W independently, respond once both are in
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate             <= W_IDLE;
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= OKAY;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      aw_word_q          <= '0;
      wdata_q            <= '0;
      wstrb_q            <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi_lite_awready <= !(aw_done || aw_hs);
          s_axi_lite_wready  <= !(w_done || w_hs);
          if (aw_hs) begin
            aw_done   <= 1'b1;
            aw_word_q <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
          end
          if (w_hs) begin
            w_done  <= 1'b1;
            wdata_q <= s_axi_lite_wdata;
            wstrb_q <= s_axi_lite_wstrb;
          end
          if (commit) begin
            wstate            <= W_RESP;
            s_axi_lite_bvalid <= 1'b1;
            s_axi_lite_bresp  <= wr_resp;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axi_lite_bready) begin
            wstate             <= W_IDLE;
            s_axi_lite_bvalid  <= 1'b0;
            s_axi_lite_awready <= 1'b1;
            s_axi_lite_wready  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Config registers with byte-lane enables
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (c_idx == 32'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (c_strb[b]) cfg_q[i][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  // FIFO storage; contents need no reset since level gates visibility
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= c_data;
  end

  // FIFO pointers and level; flush wins over a same-cycle pop
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag, set by a push into a full FIFO
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Read decode from current register state
  always_comb begin
    r_idx   = 32'(s_axi_lite_araddr[ADDR_WIDTH-1:2]);
    rd_val  = '0;
    rd_resp = SLVERR;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (r_idx == 32'(i)) begin
        rd_val  = cfg_q[i];
        rd_resp = OKAY;
      end
    end
    for (int i = 0; i < NUM_STATUS; i++) begin
      if (r_idx == IDX_STATUS + 32'(i)) begin
        rd_val  = status[32*i +: 32];
        rd_resp = OKAY;
      end
    end
    if (r_idx == IDX_CMD) begin
      rd_val  = 32'(count);
      rd_resp = OKAY;
    end
    if (r_idx == IDX_CTRL) begin
      rd_val  = {23'd0, overflow, 6'd0, full, empty};
      rd_resp = OKAY;
    end
  end

  // Read channel FSM: register data on AR handshake, hold until accepted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate             <= R_IDLE;
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rdata   <= '0;
      s_axi_lite_rresp   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate             <= R_DATA;
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rvalid  <= 1'b1;
            s_axi_lite_rdata   <= rd_val;
            s_axi_lite_rresp   <= rd_resp;
          end else begin
            s_axi_lite_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_lite_rready) begin
            rstate             <= R_IDLE;
            s_axi_lite_rvalid  <= 1'b0;
            s_axi_lite_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ctrl_regfile.sv
module tb_adc_ctrl_regfile;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] cfg;
  logic [63:0] status;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  r;
  logic [31:0] d;
  int          k, n;
  bit          seen;

  always #5 aclk = ~aclk;

  adc_ctrl_regfile dut (
    .aclk(aclk), .aresetn(aresetn), .cfg(cfg), .status(status),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(awprot), .s_axi_lite_awvalid(awvalid),
    .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arprot(arprot), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    int  cyc;
    bit  aw_ok, w_ok, got_b, hs_aw, hs_w;
    cyc = 0; aw_ok = 0; w_ok = 0; got_b = 0;
    resp = 2'b11;
    @(negedge aclk);
    awaddr = a; wdata = dat; wstrb = s;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      awvalid = !aw_ok && (cyc >= aw_dly);
      wvalid  = !w_ok && (cyc >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk);
      aw_ok = aw_ok || hs_aw;
      w_ok  = w_ok || hs_w;
      @(negedge aclk);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_handshake", {31'd0, aw_ok && w_ok}, 32'd1);
    bready = 1; cyc = 0;
    while (!got_b && cyc < 40) begin
      if (bvalid) begin
        got_b = 1;
        resp = bresp;
      end
      @(negedge aclk);
      cyc++;
    end
    bready = 0;
    chk("bvalid_seen", {31'd0, got_b}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int cyc;
    bit ar_ok, got_r;
    cyc = 0; ar_ok = 0; got_r = 0;
    dat = 32'hxxxxxxxx; resp = 2'b11;
    @(negedge aclk);
    araddr = a; arvalid = 1;
    while (!ar_ok && cyc < 40) begin
      if (arready) ar_ok = 1;
      @(negedge aclk);
      cyc++;
    end
    arvalid = 0;
    chk("ar_handshake", {31'd0, ar_ok}, 32'd1);
    rready = 1; cyc = 0;
    while (!got_r && cyc < 40) begin
      if (rvalid) begin
        got_r = 1;
        dat = rdata;
        resp = rresp;
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 0;
    chk("rvalid_seen", {31'd0, got_r}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    aresetn = 0;
    status = {32'hCAFE0001, 32'h00001234};
    m_axis_tready = 0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;

    // 1: reset state and ready release timing
    repeat (3) @(negedge aclk);
    chk("rst_cfg", cfg[31:0], 32'h0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 32'd0);
    aresetn = 1;
    #1;
    chk("rel_readies_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    @(posedge aclk); #1;
    chk("rel_readies_first_edge", {29'd0, awready, wready, arready}, 32'h7);

    // 2: AW then W two cycles later, partial strobes
    axi_write(32'h04, 32'hDEADBEEF, 4'b0101, 0, 2, r);
    chk("cfg1_bresp", {30'd0, r}, 32'd0);
    chk("cfg1_value", cfg[63:32], 32'h00AD00EF);
    axi_read(32'h04, d, r);
    chk("cfg1_read", d, 32'h00AD00EF);
    chk("cfg1_rresp", {30'd0, r}, 32'd0);

    // 3: fill FIFO with ADC stalled, overflow on 17th
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h80, 32'h100 + i, 4'hF, 0, 0, r);
      chk("cmd_push_resp", {30'd0, r}, (i < 16) ? 32'd0 : 32'd2);
    end
    axi_read(32'h84, d, r);
    chk("ctrl_full_ovf", d, 32'h102);
    axi_read(32'h80, d, r);
    chk("level_full", d, 32'd16);
    @(negedge aclk);
    m_axis_tready = 1;
    k = 0; n = 0;
    while (k < 16 && n < 60) begin
      if (m_axis_tvalid) begin
        chk("drain_order", m_axis_tdata, 32'h100 + k);
        k++;
      end
      @(negedge aclk);
      n++;
    end
    chk("drain_count", k, 32'd16);
    chk("drain_tvalid_low", {31'd0, m_axis_tvalid}, 32'd0);
    m_axis_tready = 0;

    // 4: push and pop in the same cycle keep the level, then flush
    for (int i = 0; i < 3; i++) axi_write(32'h80, 32'hA0 + i, 4'hF, 0, 0, r);
    @(negedge aclk);
    chk("pp_ready", {30'd0, awready, wready}, 32'h3);
    awaddr = 32'h80; wdata = 32'hA3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    m_axis_tready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0; m_axis_tready = 0;
    chk("pp_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pp_bresp", {30'd0, bresp}, 32'd0);
    bready = 1;
    @(negedge aclk);
    bready = 0;
    axi_read(32'h80, d, r);
    chk("pp_level", d, 32'd3);
    chk("pp_head", m_axis_tdata, 32'hA1);
    axi_write(32'h84, 32'h1, 4'hF, 0, 0, r);
    chk("flush_resp", {30'd0, r}, 32'd0);
    chk("flush_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    axi_read(32'h80, d, r);
    chk("flush_level", d, 32'd0);
    axi_read(32'h84, d, r);
    chk("ctrl_after_flush", d, 32'h101);
    axi_write(32'h84, 32'h100, 4'hF, 0, 0, r);
    axi_read(32'h84, d, r);
    chk("ctrl_ovf_cleared", d, 32'h001);

    // 5: error responses and status reads
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    chk("ro_write_resp", {30'd0, r}, 32'd2);
    axi_read(32'h40, d, r);
    chk("status0_read", d, 32'h1234);
    chk("status0_rresp", {30'd0, r}, 32'd0);
    axi_read(32'h44, d, r);
    chk("status1_read", d, 32'hCAFE0001);
    axi_read(32'hFC, d, r);
    chk("unmapped_rdata", d, 32'h0);
    chk("unmapped_rresp", {30'd0, r}, 32'd2);
    axi_read(32'h08, d, r);
    chk("cfg2_unmapped_rresp", {30'd0, r}, 32'd2);
    axi_write(32'h08, 32'h55, 4'hF, 0, 0, r);
    chk("cfg2_unmapped_wresp", {30'd0, r}, 32'd2);
    axi_write(32'h00, 32'h11223344, 4'hF, 1, 0, r);
    chk("cfg0_full_write", cfg[31:0], 32'h11223344);
    axi_write(32'h00, 32'hFFFFFFFF, 4'h0, 0, 0, r);
    chk("cfg0_nostrb_resp", {30'd0, r}, 32'd0);
    chk("cfg0_nostrb_value", cfg[31:0], 32'h11223344);
    chk("cfg1_untouched", cfg[63:32], 32'h00AD00EF);
    axi_write(32'h80, 32'hBAD, 4'h3, 0, 0, r);
    chk("cmd_partial_strb_resp", {30'd0, r}, 32'd2);
    chk("cmd_partial_no_push", {31'd0, m_axis_tvalid}, 32'd0);

    // 6: reset while a response is pending and FIFO holds words
    for (int i = 0; i < 5; i++) axi_write(32'h80, 32'hB0 + i, 4'hF, 0, 0, r);
    @(negedge aclk);
    awaddr = 32'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    chk("pend_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pend_cfg0", cfg[31:0], 32'h55);
    chk("pend_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    #2 aresetn = 0;
    #1;
    chk("arst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_cfg", cfg, 32'h0);
    chk("arst_cfg_hi", cfg[63:32], 32'h0);
    @(negedge aclk);
    aresetn = 1;
    bready = 1;
    seen = 0;
    repeat (10) begin
      @(negedge aclk);
      if (bvalid) seen = 1;
    end
    bready = 0;
    chk("no_resp_after_reset", {31'd0, seen}, 32'd0);
    chk("readies_after_reset", {30'd0, awready, wready}, 32'h3);
    axi_read(32'h80, d, r);
    chk("level_after_reset", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
